wvb_rd_sequencer: RTL and testbench

- Drives the waveform-buffer read side, sitting directly upstream of the rd-address controller.
- Pops one event header from the header FIFO, issues `hdr_rdreq`, then waits for the address controller to load `start_addr`.
- Streams every sample from `start_addr` to `stop_addr` out of the waveform RAM to a downstream valid/ready consumer, then pulses `wvb_rddone`.
- Owns the cycle-level handshake timing the address controller depends on.

---
 rtl/wvb_rd_sequencer.sv | 141 ++++++++++++++
 tb/tb_wvb_rd_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wvb_rd_sequencer.sv
// wvb_rd_sequencer: pops an event header, streams its waveform samples to a valid/ready sink, pulses done.
// Define WVB_RD_SEQ_ABORT_EN to add the abort input and its flush/early-done path.
module wvb_rd_sequencer #(
   parameter int P_ADR_WIDTH  = 12,
   parameter int P_HDR_WIDTH  = 80,
   parameter int P_DATA_WIDTH = 22,
   parameter int P_RD_LAT     = 2,
   parameter int P_OBUF_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    hdr_empty,
   input  logic [P_HDR_WIDTH-1:0]  hdr_data,
   output logic                    hdr_rdreq,
   output logic                    wvb_rdreq,
   output logic                    wvb_rddone,
   input  logic [P_DATA_WIDTH-1:0] wvb_data,
   output logic [P_DATA_WIDTH-1:0] dout,
   output logic                    dout_valid,
   output logic                    dout_first,
   output logic                    dout_last,
   input  logic                    dout_rdy,
   output logic [P_HDR_WIDTH-1:0]  evt_hdr,
   output logic                    busy,
   output logic [15:0]             evt_cnt
`ifdef WVB_RD_SEQ_ABORT_EN
   ,
   input  logic                    abort
`endif
);
   localparam int AW = P_ADR_WIDTH;
   localparam int RW = P_ADR_WIDTH + 1;
   localparam int L  = P_RD_LAT + 1;
   localparam int PW = $clog2(P_OBUF_DEPTH);
   localparam int CW = $clog2(P_OBUF_DEPTH + 1);
   localparam int OW = $clog2(L + P_OBUF_DEPTH + 1);
   localparam int BW = P_DATA_WIDTH + 2;

   typedef enum logic [2:0] {IDLE, HDR_WAIT, STREAM, DRAIN, DONE} state_t;
   state_t state, state_nx;

   logic          ph, abt, aborted, fetch_v, rd_fetch, push, pop, room;
   logic [AW-1:0] start, stop, diff;
   logic [RW-1:0] len, rem;
   logic [L-1:0]  pv, pf, pl;
   logic [OW-1:0] occ;
   logic [PW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic [BW-1:0] mem [P_OBUF_DEPTH];

`ifdef WVB_RD_SEQ_ABORT_EN
   assign abt = abort && (state == HDR_WAIT || state == STREAM || state == DRAIN);
`else
   assign abt = 1'b0;
`endif

   assign start = evt_hdr[AW-1:0];
   assign stop  = evt_hdr[2*AW-1:AW];
   assign diff  = stop - start + AW'(1);
   assign len   = {diff == '0, diff};

   // Sample 0 is a virtual fetch in the last HDR_WAIT cycle, so every sample lands L cycles after its fetch.
   always_comb begin
      occ = OW'(cnt) - OW'(pop);
      for (int i = 0; i < L; i++) occ = occ + OW'(pv[i]);
   end

   assign room     = occ < OW'(P_OBUF_DEPTH);
   assign fetch_v  = state == HDR_WAIT && ph && !abt;
   assign rd_fetch = state == STREAM && rem != '0 && room && !abt;
   assign push     = pv[L-1] && !abt;
   assign pop      = dout_valid && dout_rdy;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     state_nx = hdr_empty ? IDLE : HDR_WAIT;
         HDR_WAIT: state_nx = abt ? DONE : ph ? STREAM : HDR_WAIT;
         STREAM:   state_nx = abt ? DONE : (rem == '0 || (rd_fetch && rem == RW'(1))) ? DRAIN : STREAM;
         DRAIN:    state_nx = (abt || (pv == '0 && cnt == '0)) ? DONE : DRAIN;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      hdr_rdreq  = rst_n && state == IDLE && !hdr_empty;
      wvb_rdreq  = rd_fetch;
      wvb_rddone = state == DONE;
      busy       = state != IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ph      <= 1'b0;
         rem     <= '0;
         evt_hdr <= '0;
         evt_cnt <= '0;
         aborted <= 1'b0;
         pv      <= '0;
         pf      <= '0;
         pl      <= '0;
      end else begin
         ph <= state == HDR_WAIT && !ph && !abt;
         if (state == HDR_WAIT && !ph) evt_hdr <= hdr_data;
         if (fetch_v) rem <= len - RW'(1);
         else if (rd_fetch) rem <= rem - RW'(1);
         evt_cnt <= evt_cnt + 16'(state == DONE && !aborted);
         aborted <= abt || (aborted && state != DONE);
         pv      <= abt ? '0 : {pv[L-2:0], fetch_v || rd_fetch};
         pf      <= {pf[L-2:0], fetch_v};
         pl      <= {pl[L-2:0], fetch_v ? len == RW'(1) : rem == RW'(1)};
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (abt) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= (wp == PW'(P_OBUF_DEPTH - 1)) ? '0 : wp + PW'(1);
         if (pop) rp <= (rp == PW'(P_OBUF_DEPTH - 1)) ? '0 : rp + PW'(1);
         cnt <= cnt + CW'(push) - CW'(pop);
      end

   always_ff @(posedge clk)
      if (push) mem[wp] <= {pf[L-1], pl[L-1], wvb_data};

   always_comb begin
      dout_valid                    = cnt != '0;
      {dout_first, dout_last, dout} = dout_valid ? mem[rp] : '0;
   end
endmodule

// File: tb/tb_wvb_rd_sequencer.sv
// tb_wvb_rd_sequencer: header FIFO, address controller and waveform RAM models around wvb_rd_sequencer.
// Expected words are queued when a header is issued and popped by a separate output monitor.
module tb_wvb_rd_sequencer;
   localparam int AW = 12, HW = 80, DW = 22, DEPTH = 4;

   logic          clk = 1'b0, rst_n = 1'b0, hdr_empty = 1'b1, dout_rdy = 1'b0;
   logic [HW-1:0] hdr_data = '0;
   logic [DW-1:0] wvb_data, dout;
   logic [AW-1:0] rd_addr = '0, a1 = '0, a2 = '0;
   logic [15:0]   evt_cnt;
   logic [HW-1:0] evt_hdr, cur_hdr = '0;
   logic          hdr_rdreq, wvb_rdreq, wvb_rddone, dout_valid, dout_first, dout_last, busy;
   logic          rq_s = 1'b0, wr_s = 1'b0, stall_prev = 1'b0, in_evt = 1'b0;
   logic [DW+2:0] held = '0;
   logic [HW-1:0] hq[$];
   logic [DW+1:0] exp_q[$];
   int checks = 0, errors = 0, ld = 0, ndone = 0, ev_xfer = 0, nrd = 0, occ = 0, maxocc = 0;
   int cur_len = 0, ncyc = 0, last_xfer = 0, rdy_mode = 0, rc = 0, hn = 0;

   always #5 clk = ~clk;

   wvb_rd_sequencer dut (
      .clk(clk), .rst_n(rst_n), .hdr_empty(hdr_empty), .hdr_data(hdr_data), .hdr_rdreq(hdr_rdreq),
      .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone), .wvb_data(wvb_data), .dout(dout),
      .dout_valid(dout_valid), .dout_first(dout_first), .dout_last(dout_last), .dout_rdy(dout_rdy),
      .evt_hdr(evt_hdr), .busy(busy), .evt_cnt(evt_cnt)
   );

   function automatic logic [DW-1:0] ram(input logic [AW-1:0] a);
      return {10'h2A5, a};
   endfunction

   function automatic int hdr_len(input logic [HW-1:0] h);
      logic [AW-1:0] d;
      d = h[2*AW-1:AW] - h[AW-1:0] + 1'b1;
      return d == '0 ? (1 << AW) : int'(d);
   endfunction

   task automatic chk(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic push_hdr(input logic [AW-1:0] s, input logic [AW-1:0] e);
      logic [HW-1:0] h;
      logic [AW-1:0] a;
      int n;
      h = {8'hA5, 24'(hn), 24'h5A5A5A, e, s};
      hn++;
      n = hdr_len(h);
      a = s;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({k == 0, k == n - 1, ram(a)});
         a = a + 1'b1;
      end
      hq.push_back(h);
   endtask

   task automatic run(input int n);
      int tgt;
      tgt = ndone + n;
      for (int i = 0; i < 3000 && ndone < tgt; i++) @(posedge clk);
      chk("evt_done_timeout", ndone >= tgt, 1);
      repeat (3) @(posedge clk);
      #2;
      chk("idle_after_evt", busy, 0);
   endtask

   // Header FIFO pops on hdr_rdreq; the address controller loads start at T+3 and steps on wvb_rdreq.
   always @(posedge clk) begin
      if (!rst_n) begin
         ld        <= 0;
         hdr_empty <= hq.size() == 0;
      end else begin
         if (rq_s && hq.size() != 0) begin
            hdr_data <= hq.pop_front();
            ld       <= 2;
         end else if (ld != 0) ld <= ld - 1;
         if (ld == 1) rd_addr <= hdr_data[AW-1:0];
         else if (wr_s) rd_addr <= rd_addr + 1'b1;
         hdr_empty <= hq.size() == 0;
      end
      a1 <= rd_addr;
      a2 <= a1;
   end

   assign wvb_data = ram(a2);

   initial forever begin
      @(posedge clk);
      #1;
      dout_rdy = (rdy_mode == 0) || (rc % 3 == 0);
      rc++;
   end

   always @(negedge clk) begin
      logic [DW+1:0] e;
      ncyc++;
      rq_s = rst_n && hdr_rdreq;
      wr_s = rst_n && wvb_rdreq;
      if (!rst_n) begin
         in_evt     = 1'b0;
         occ        = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) chk("stall_hold", {dout_valid, dout_first, dout_last, dout}, held);
         if (dout_valid && dout_rdy) begin
            chk("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("dout_word", {dout_first, dout_last, dout}, e);
            end
            if (in_evt && ev_xfer > 0 && rdy_mode == 0) chk("zero_bubble", ncyc - last_xfer, 1);
            last_xfer = ncyc;
            ev_xfer++;
         end
         stall_prev = dout_valid && !dout_rdy;
         held       = {dout_valid, dout_first, dout_last, dout};
         if (wvb_rdreq) begin
            chk("rdreq_before_t3", ld, 0);
            chk("rdreq_in_evt", in_evt, 1);
            nrd++;
         end
         occ = occ + int'(wvb_rdreq) + int'(ld == 1) - int'(dout_valid && dout_rdy);
         if (occ > maxocc) maxocc = occ;
         if (hdr_rdreq) chk("hdr_rdreq_while_busy", in_evt, 0);
         if (wvb_rddone) begin
            chk("rddone_in_evt", in_evt, 1);
            chk("evt_words", ev_xfer, cur_len);
            chk("evt_rdreqs", nrd, cur_len - 1);
            chk("evt_hdr", evt_hdr, cur_hdr);
            chk("max_occupancy_ok", maxocc <= DEPTH, 1);
            in_evt = 1'b0;
            ndone++;
         end
         if (hdr_rdreq) begin
            chk("hdr_rdreq_nonempty", hq.size() != 0, 1);
            if (hq.size() != 0) cur_hdr = hq[0];
            cur_len = hdr_len(cur_hdr);
            in_evt  = 1'b1;
            ev_xfer = 0;
            nrd     = 0;
            maxocc  = 0;
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout", {dout_first, dout_last, dout}, 0);
      chk("rst_evt_cnt", evt_cnt, 0);
      chk("rst_evt_hdr", evt_hdr, 0);
      chk("rst_pulses", {hdr_rdreq, wvb_rdreq, wvb_rddone}, 0);
      rst_n = 1'b1;
      push_hdr(12'h010, 12'h013);
      run(1);
      chk("evt_cnt_1", evt_cnt, 1);
      push_hdr(12'h200, 12'h200);
      run(1);
      chk("evt_cnt_single", evt_cnt, 2);
      push_hdr(12'hFFE, 12'h001);
      run(1);
      chk("evt_cnt_wrap", evt_cnt, 3);
      rdy_mode = 1;
      push_hdr(12'h400, 12'h407);
      run(1);
      rdy_mode = 0;
      chk("evt_cnt_bp", evt_cnt, 4);
      push_hdr(12'h500, 12'h502);
      push_hdr(12'h600, 12'h60B);
      run(2);
      chk("evt_cnt_b2b", evt_cnt, 6);
      push_hdr(12'h100, 12'h10F);
      for (int i = 0; i < 200 && !(in_evt && ev_xfer >= 3); i++) @(posedge clk);
      chk("midstream_reached", in_evt && ev_xfer >= 3, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_dout_valid", dout_valid, 0);
      chk("arst_dout", {dout_first, dout_last, dout}, 0);
      chk("arst_evt_cnt", evt_cnt, 0);
      chk("arst_evt_hdr", evt_hdr, 0);
      chk("arst_pulses", {hdr_rdreq, wvb_rdreq, wvb_rddone}, 0);
      hq.delete();
      exp_q.delete();
      push_hdr(12'h700, 12'h705);
      repeat (2) @(posedge clk);
      #2;
      chk("arst_hdr_rdreq_gated", hdr_rdreq, 0);
      rst_n = 1'b1;
      run(1);
      chk("evt_cnt_after_rst", evt_cnt, 1);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
